// File: rtl/fibonacci_index.sv
// Fibonacci index finder: walks F(0), F(1), ... one comparison per clock and
// reports the exact or floor index of a 32-bit value through a start/done handshake.
module fibonacci_index (
    input  logic        clk,
    input  logic        rst,
    input  logic        st,
    input  logic [31:0] x,
    output logic [7:0]  idx,
    output logic        hit,
    output logic        done,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [7:0] K_MAX = 8'd47;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] xr;
    logic [31:0] xr_nxt;
    logic [31:0] a;
    logic [31:0] a_nxt;
    logic [31:0] b;
    logic [31:0] b_nxt;
    logic [7:0]  k;
    logic [7:0]  k_nxt;
    logic [7:0]  idx_nxt;
    logic        hit_nxt;
    logic        done_nxt;
    logic        busy_nxt;

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            xr    <= 32'd0;
            a     <= 32'd0;
            b     <= 32'd0;
            k     <= 8'd0;
            idx   <= 8'd0;
            hit   <= 1'b0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            xr    <= xr_nxt;
            a     <= a_nxt;
            b     <= b_nxt;
            k     <= k_nxt;
            idx   <= idx_nxt;
            hit   <= hit_nxt;
            done  <= done_nxt;
            busy  <= busy_nxt;
        end
    end

    // Next-state and next-datapath logic; the search stops at the first term >= target.
    always_comb begin
        state_nxt = state;
        xr_nxt    = xr;
        a_nxt     = a;
        b_nxt     = b;
        k_nxt     = k;
        idx_nxt   = idx;
        hit_nxt   = hit;
        case (state)
            IDLE: begin
                if (st) begin
                    xr_nxt    = x;
                    a_nxt     = 32'd0;
                    b_nxt     = 32'd1;
                    k_nxt     = 8'd0;
                    state_nxt = SEARCH;
                end else begin
                    state_nxt = IDLE;
                end
            end
            SEARCH: begin
                if (a == xr) begin
                    hit_nxt   = 1'b1;
                    idx_nxt   = k;
                    state_nxt = DONE;
                end else if (a > xr) begin
                    // a overshot, so the previous term is the floor; k >= 1 here since F(0)=0
                    hit_nxt   = 1'b0;
                    idx_nxt   = k - 8'd1;
                    state_nxt = DONE;
                end else if (k == K_MAX) begin
                    hit_nxt   = 1'b0;
                    idx_nxt   = K_MAX;
                    state_nxt = DONE;
                end else begin
                    // b wraps after F(47); it is never compared, so the wrap is harmless
                    a_nxt     = b;
                    b_nxt     = a + b;
                    k_nxt     = k + 8'd1;
                    state_nxt = SEARCH;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        done_nxt = (state_nxt == DONE);
        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_fibonacci_index.sv
// Self-checking bench for fibonacci_index: per-cycle model comparison plus
// directed lookups with hand-computed index, hit and latency.
module tb_fibonacci_index;

    logic        clk;
    logic        rst;
    logic        st;
    logic [31:0] x;
    logic [7:0]  idx;
    logic        hit;
    logic        done;
    logic        busy;

    int tests = 0;
    int fails = 0;

    fibonacci_index dut (
        .clk  (clk),
        .rst  (rst),
        .st   (st),
        .x    (x),
        .idx  (idx),
        .hit  (hit),
        .done (done),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: exact index (smallest on ties) if x is Fibonacci, else the largest
    // index whose term is below x; j is the index at which the walk decides.
    function automatic void model(input logic [31:0] v, output int m_idx,
                                  output bit m_hit, output int m_j);
        longint unsigned f[0:47];
        f[0] = 0;
        f[1] = 1;
        for (int i = 2; i <= 47; i++) f[i] = f[i-1] + f[i-2];
        m_hit = 1'b0;
        m_idx = 0;
        for (int i = 0; i <= 47; i++) begin
            if (!m_hit && f[i] == longint'(v)) begin
                m_hit = 1'b1;
                m_idx = i;
            end
        end
        if (!m_hit) begin
            for (int i = 0; i <= 47; i++) if (f[i] < longint'(v)) m_idx = i;
        end
        if (m_hit)            m_j = m_idx;
        else if (m_idx == 47) m_j = 47;
        else                  m_j = m_idx + 1;
    endfunction

    // Cycle-level expectation tracked by the checker process.
    int cyc = 0;
    int e0 = 0;
    bit seen_rst = 1'b0;
    bit active = 1'b0;
    int e_idx = 0;
    bit e_hit = 1'b0;
    int e_j = 0;
    int h_idx = 0;
    bit h_hit = 1'b0;

    // Per-cycle compare of all outputs against the model, sampled just after each edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (rst) begin
            seen_rst = 1'b1;
            active   = 1'b0;
            h_idx    = 0;
            h_hit    = 1'b0;
        end else if (seen_rst) begin
            if (active) begin
                if (cyc - e0 == e_j + 1) begin
                    h_idx = e_idx;
                    h_hit = e_hit;
                end else if (cyc - e0 == e_j + 2) begin
                    active = 1'b0;
                end
            end else if (st) begin
                active = 1'b1;
                e0     = cyc;
                model(x, e_idx, e_hit, e_j);
            end
        end
        if (seen_rst) begin
            check("cyc_busy", longint'(busy), longint'(active));
            check("cyc_done", longint'(done), longint'(active && (cyc - e0 == e_j + 1)));
            check("cyc_idx",  longint'(idx),  longint'(h_idx));
            check("cyc_hit",  longint'(hit),  longint'(h_hit));
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 1, 0);
    endtask

    task automatic run(input logic [31:0] v, input int exp_idx, input bit exp_hit,
                       input int exp_lat, input string name);
        int cnt;
        wait_idle();
        x   = v;
        st  = 1'b1;
        cnt = 0;
        while (cnt < 60) begin
            @(negedge clk);
            st = 1'b0;
            cnt++;
            if (done) break;
        end
        if (!done) begin
            check({name, "_timeout"}, 1, 0);
        end else begin
            check({name, "_idx"}, longint'(idx), longint'(exp_idx));
            check({name, "_hit"}, longint'(hit), longint'(exp_hit));
            check({name, "_lat"}, longint'(cnt), longint'(exp_lat));
        end
    endtask

    int m_idx;
    bit m_hit;
    int m_j;

    initial begin
        int cnt;
        rst = 1'b1;
        st  = 1'b0;
        x   = 32'd0;

        // Pin the model itself against hand-computed values.
        model(32'd100, m_idx, m_hit, m_j);
        check("model_100_idx", longint'(m_idx), 11);
        check("model_100_j", longint'(m_j), 12);
        model(32'hB11924E1, m_idx, m_hit, m_j);
        check("model_f47_hit", longint'(m_hit), 1);
        model(32'd2, m_idx, m_hit, m_j);
        check("model_2_idx", longint'(m_idx), 3);

        repeat (3) @(negedge clk);
        check("rst_idx",  longint'(idx),  0);
        check("rst_hit",  longint'(hit),  0);
        check("rst_done", longint'(done), 0);
        check("rst_busy", longint'(busy), 0);
        rst = 1'b0;
        @(negedge clk);

        run(32'd0,          0,  1'b1, 2,  "x0");
        run(32'd1,          1,  1'b1, 3,  "x1");
        run(32'd144,        12, 1'b1, 14, "x144");
        run(32'd100,        11, 1'b0, 14, "x100");
        run(32'd4,          4,  1'b0, 7,  "x4");
        run(32'hB11924E1,   47, 1'b1, 49, "xf47");
        run(32'hFFFFFFFF,   47, 1'b0, 49, "xmax");

        // st and x changes during SEARCH must be ignored.
        wait_idle();
        x   = 32'd144;
        st  = 1'b1;
        cnt = 0;
        while (cnt < 60) begin
            @(negedge clk);
            cnt++;
            if (cnt >= 3 && cnt <= 6) begin
                st = 1'b1;
                x  = 32'd5;
            end else begin
                st = 1'b0;
            end
            if (done) break;
        end
        if (!done) begin
            check("ign_timeout", 1, 0);
        end else begin
            check("ign_idx", longint'(idx), 12);
            check("ign_hit", longint'(hit), 1);
            check("ign_lat", longint'(cnt), 14);
        end
        run(32'd5, 5, 1'b1, 7, "x5_after");

        // Reset mid-search aborts with no done.
        wait_idle();
        x  = 32'hFFFFFFFF;
        st = 1'b1;
        @(negedge clk);
        st = 1'b0;
        repeat (19) @(negedge clk);
        check("abort_busy_before", longint'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_idx",  longint'(idx),  0);
        check("abort_hit",  longint'(hit),  0);
        check("abort_busy", longint'(busy), 0);
        check("abort_done", longint'(done), 0);
        @(negedge clk);
        run(32'd8, 6, 1'b1, 8, "x8");

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
